e1_crc_engine: RTL and testbench
================================

Name: e1_crc_engine

Overview:
- Parametrised successor to the bit-serial E1 CRC-4 generator: configurable CRC width, polynomial, init value and bits per cycle.
- Delimits blocks with first/last markers and registers each finished CRC with a valid pulse.
- Holds the last CRC until the reference value arrives and flags match/mismatch. In E1 the CRC bits of a sub-multiframe (SMF) arrive in the next SMF.
- Sits between the E1 framer bit stream and the CRC-4 multiframe alignment/monitoring logic.

Parameters:
- W, 4, CRC width in bits (2..16).
- POLY, 4'h3, generator polynomial without the implicit x^W term, W bits wide.
- INIT, 4'h0, state loaded at block start, W bits wide.
- N, 1, data bits consumed per in_valid beat (1..8); in_data[N-1] is processed first.
- CNT_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N  data bits, MSB first.
- in_first  in  1  beat is the first of a block; qualified by in_valid.
- in_last  in  1  beat is the last of a block; qualified by in_valid.
- in_valid  in  1  beat valid.
- out_crc  out  W  CRC of the most recently completed block.
- out_valid  out  1  one-cycle pulse: out_crc updated.
- chk_ref  in  W  received CRC for the held block.
- chk_ref_valid  in  1  one-cycle strobe for chk_ref.
- chk_done  out  1  one-cycle pulse: comparison result valid.
- chk_ok  out  1  comparison result; valid while chk_done=1.
- chk_ovr  out  1  pulse: an unchecked held CRC was overwritten.
- err_cnt  out  CNT_W  saturating mismatch count.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async assert): state=INIT, out_crc=0, out_valid=0, pending=0, chk_done=0, chk_ok=0, chk_ovr=0, err_cnt=0. Reset mid-block discards the partial block.
- Per-bit step, Galois form:
  - fb = s[W-1] XOR bit
  - s' = {s[W-2:0],0} XOR (fb ? POLY : 0)
  - Each beat applies N steps combinationally, in_data[N-1] first.
- Start of block: when in_valid and in_first, the step chain starts from INIT instead of the state register.
  - in_first mid-block silently restarts the block.
- Data with no block in progress (before any in_first) still updates the state. Such a result is never reported unless in_last occurs.
- in_valid=0: state holds and all inputs are ignored.
- in_valid & in_last, next cycle:
  - out_crc = post-beat state.
  - out_valid=1 for one cycle.
  - pending=1; the held value is the new out_crc.
  - State register still loads the post-beat state.
- Single-beat block: in_first and in_last on the same beat is legal.
- Latency: out_crc/out_valid one cycle after the last beat.
- Check: chk_ref_valid with pending=1 gives, next cycle:
  - chk_done=1, chk_ok=(chk_ref==out_crc), pending=0.
  - chk_ref_valid with pending=0 is ignored (no chk_done).
- Simultaneous completion and chk_ref_valid in the same cycle:
  - Compare against the currently held (old) out_crc.
  - Then load the new CRC with pending=1; no chk_ovr.
- Completion while pending=1 and no chk_ref_valid that cycle: chk_ovr pulses one cycle, together with out_valid; pending stays 1.
- err_cnt:
  - Increments on chk_done & !chk_ok.
  - Saturates at 2^CNT_W-1.
  - err_clr has priority over an increment in the same cycle.

Optional Feature:
- Macro: E1_CRC_ERRCNT_EN.
- Defined: err_cnt and err_clr behave as above.
- Undefined: no counter is instantiated, err_cnt is tied to 0, and err_clr is ignored. chk_done/chk_ok are unaffected.

Test Plan:
- W=4, POLY=3, INIT=0, N=1; bits 1,0,0,0 with first on bit 1 and last on bit 4 -> out_crc=4'hB and out_valid pulse one cycle after bit 4.
- Same config with N=4; single beat in_data=4'h8, first=last=1 -> out_crc=4'hB next cycle. Then in_data=4'h0 (first/last) -> out_crc=4'h0.
- Block giving 4'hB, then chk_ref=4'hB strobe -> chk_done=1, chk_ok=1. Next block giving 4'hB, then chk_ref=4'h3 -> chk_ok=0, err_cnt=1. A chk_ref strobe with nothing pending -> no chk_done.
- Two blocks completing with no chk_ref between them -> chk_ovr pulse on the second out_valid. chk_ref strobe in the same cycle as the third block's last beat -> compared against the second CRC, no chk_ovr.
- CNT_W=2, five mismatches -> err_cnt=3. err_clr on the same cycle as a mismatch chk_done -> err_cnt=0.
- Assert rst mid-block (after 2 of 4 bits), then a full block of bits 1,0,0,0 -> out_crc=4'hB. Verify all outputs read 0 during reset.

Source files
------------

// File: rtl/e1_crc_engine.sv
// e1_crc_engine: parametrised N-bits-per-beat Galois CRC with block markers, held-CRC check and mismatch counting.
// Define E1_CRC_ERRCNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied to 0.
module e1_crc_engine #(
  parameter int W = 4,
  parameter logic [W-1:0] POLY = 4'h3,
  parameter logic [W-1:0] INIT = 4'h0,
  parameter int N = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_valid,
  output logic [W-1:0]     out_crc,
  output logic             out_valid,
  input  logic [W-1:0]     chk_ref,
  input  logic             chk_ref_valid,
  output logic             chk_done,
  output logic             chk_ok,
  output logic             chk_ovr,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);
  logic [W-1:0] state, nxt;
  logic pending, done, chk_go;
  assign done = in_valid & in_last;
  assign chk_go = chk_ref_valid & pending;
  always_comb begin
    nxt = (in_valid && in_first) ? INIT : state;
    for (int i = N - 1; i >= 0; i--)
      nxt = {nxt[W-2:0], 1'b0} ^ ((nxt[W-1] ^ in_data[i]) ? POLY : '0);
  end
  // The compare always sees the CRC held before this cycle's completion lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      out_crc <= '0;
      out_valid <= 1'b0;
      pending <= 1'b0;
      chk_done <= 1'b0;
      chk_ok <= 1'b0;
      chk_ovr <= 1'b0;
    end else begin
      out_valid <= done;
      chk_done <= chk_go;
      chk_ovr <= done & pending & ~chk_go;
      pending <= done | (pending & ~chk_go);
      if (in_valid) state <= nxt;
      if (done) out_crc <= nxt;
      if (chk_go) chk_ok <= (chk_ref == out_crc);
    end
  end
`ifdef E1_CRC_ERRCNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (err_clr) cnt <= '0;
    else if (chk_done && !chk_ok && cnt != '1) cnt <= cnt + 1'b1;
  end
  assign err_cnt = cnt;
`else
  logic unused;
  assign unused = err_clr;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_e1_crc_engine.sv
// tb_e1_crc_engine: directed and randomized checks of two e1_crc_engine instances (N=1/CNT_W=8 and N=4/CNT_W=2).
// The reference CRC is computed by polynomial long division of the augmented message.
module tb_e1_crc_engine;
  typedef bit bq_t[$];
`ifdef E1_CRC_ERRCNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam logic [3:0] POLY_T = 4'h3;
  localparam logic [3:0] INIT_T = 4'h0;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, fails = 0;
  logic a_d = 1'b0, a_f = 1'b0, a_l = 1'b0, a_v = 1'b0, a_rv = 1'b0, a_clr = 1'b0;
  logic [3:0] a_ref = '0, a_crc;
  logic a_ov, a_cd, a_ok, a_ovr;
  logic [7:0] a_cnt;
  logic [3:0] b_d = '0, b_ref = '0, b_crc;
  logic b_f = 1'b0, b_l = 1'b0, b_v = 1'b0, b_rv = 1'b0, b_clr = 1'b0;
  logic b_ov, b_cd, b_ok, b_ovr;
  logic [1:0] b_cnt;
  always #5 clk = ~clk;

  e1_crc_engine #(.W(4), .POLY(POLY_T), .INIT(INIT_T), .N(1), .CNT_W(8)) d1 (
    .clk(clk), .rst(rst), .in_data(a_d), .in_first(a_f), .in_last(a_l), .in_valid(a_v),
    .out_crc(a_crc), .out_valid(a_ov), .chk_ref(a_ref), .chk_ref_valid(a_rv),
    .chk_done(a_cd), .chk_ok(a_ok), .chk_ovr(a_ovr), .err_cnt(a_cnt), .err_clr(a_clr));

  e1_crc_engine #(.W(4), .POLY(POLY_T), .INIT(INIT_T), .N(4), .CNT_W(2)) d4 (
    .clk(clk), .rst(rst), .in_data(b_d), .in_first(b_f), .in_last(b_l), .in_valid(b_v),
    .out_crc(b_crc), .out_valid(b_ov), .chk_ref(b_ref), .chk_ref_valid(b_rv),
    .chk_done(b_cd), .chk_ok(b_ok), .chk_ovr(b_ovr), .err_cnt(b_cnt), .err_clr(b_clr));

  function automatic bq_t mk(input logic [31:0] v, input int n);
    bq_t q;
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
    return q;
  endfunction

  // remainder of (msg * x^4 + INIT * x^len) mod (x^4 + POLY)
  function automatic logic [3:0] crc_ref(input bq_t msg);
    bq_t a = msg;
    logic [4:0] g = {1'b1, POLY_T};
    logic [3:0] ini = INIT_T;
    int n = msg.size();
    repeat (4) a.push_back(1'b0);
    for (int i = 0; i < 4; i++) a[i] = a[i] ^ ini[3-i];
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j <= 4; j++) a[i+j] = a[i+j] ^ g[4-j];
    return {a[n], a[n+1], a[n+2], a[n+3]};
  endfunction

  task automatic a_drive(input logic v, d, f, l, rv, input logic [3:0] r, input logic clr);
    @(negedge clk);
    a_v = v; a_d = d; a_f = f; a_l = l; a_rv = rv; a_ref = r; a_clr = clr;
  endtask

  task automatic b_drive(input logic v, input logic [3:0] d, input logic f, l, rv, input logic [3:0] r, input logic clr);
    @(negedge clk);
    b_v = v; b_d = d; b_f = f; b_l = l; b_rv = rv; b_ref = r; b_clr = clr;
  endtask

  task automatic a_send(input bq_t msg, input logic rv, input logic [3:0] r);
    int n = msg.size();
    for (int i = 0; i < n; i++)
      a_drive(1'b1, msg[i], i == 0, i == n - 1, rv & (i == n - 1), r, 1'b0);
  endtask

  task automatic a_idle; a_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0); endtask
  task automatic b_idle; b_drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0); endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    tests++;
    if ({a_crc, a_ov, a_cd, a_ok, a_ovr, a_cnt} !== '0) begin
      fails++; $display("FAIL reset_a: got crc=%h ov=%b cd=%b ok=%b ovr=%b cnt=%0d, want all 0", a_crc, a_ov, a_cd, a_ok, a_ovr, a_cnt);
    end
    tests++;
    if ({b_crc, b_ov, b_cd, b_ok, b_ovr, b_cnt} !== '0) begin
      fails++; $display("FAIL reset_b: got crc=%h ov=%b cd=%b ok=%b ovr=%b cnt=%0d, want all 0", b_crc, b_ov, b_cd, b_ok, b_ovr, b_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_serial;
    a_send(mk(32'h8, 4), 1'b0, 4'h0);
    a_idle;
    tests++;
    if (a_ov !== 1'b1 || a_crc !== 4'hB || a_ovr !== 1'b0) begin
      fails++; $display("FAIL serial: got crc=%h ov=%b ovr=%b, want crc=b ov=1 ovr=0", a_crc, a_ov, a_ovr);
    end
    a_idle;
    tests++;
    if (a_ov !== 1'b0) begin
      fails++; $display("FAIL serial_pulse: out_valid=%b, want 0", a_ov);
    end
  endtask

  task automatic test_parallel;
    b_drive(1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    b_idle;
    tests++;
    if (b_ov !== 1'b1 || b_crc !== 4'hB) begin
      fails++; $display("FAIL parallel_8: got crc=%h ov=%b, want crc=b ov=1", b_crc, b_ov);
    end
    b_drive(1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    b_idle;
    tests++;
    if (b_ov !== 1'b1 || b_crc !== 4'h0 || b_ovr !== 1'b1) begin
      fails++; $display("FAIL parallel_0: got crc=%h ov=%b ovr=%b, want crc=0 ov=1 ovr=1", b_crc, b_ov, b_ovr);
    end
  endtask

  task automatic test_check;
    a_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0);
    a_idle;
    tests++;
    if (a_cd !== 1'b1 || a_ok !== 1'b1) begin
      fails++; $display("FAIL chk_match: got done=%b ok=%b, want done=1 ok=1", a_cd, a_ok);
    end
    a_send(mk(32'h8, 4), 1'b0, 4'h0);
    a_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0);
    a_idle;
    tests++;
    if (a_cd !== 1'b1 || a_ok !== 1'b0) begin
      fails++; $display("FAIL chk_mismatch: got done=%b ok=%b, want done=1 ok=0", a_cd, a_ok);
    end
    a_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0);
    tests++;
    if (a_cnt !== (EN ? 8'd1 : 8'd0)) begin
      fails++; $display("FAIL chk_errcnt: got %0d, want %0d", a_cnt, EN ? 1 : 0);
    end
    a_idle;
    tests++;
    if (a_cd !== 1'b0) begin
      fails++; $display("FAIL chk_nopend: chk_done=%b, want 0", a_cd);
    end
  endtask

  task automatic test_ovr;
    logic [3:0] x2, x3;
    x2 = crc_ref(mk(32'h09, 5));
    x3 = crc_ref(mk(32'h35, 6));
    a_send(mk(32'h8, 4), 1'b0, 4'h0);
    a_idle;
    tests++;
    if (a_ov !== 1'b1 || a_ovr !== 1'b0) begin
      fails++; $display("FAIL ovr_first: got ov=%b ovr=%b, want ov=1 ovr=0", a_ov, a_ovr);
    end
    a_send(mk(32'h09, 5), 1'b0, 4'h0);
    a_idle;
    tests++;
    if (a_ov !== 1'b1 || a_ovr !== 1'b1 || a_crc !== x2) begin
      fails++; $display("FAIL ovr_second: got crc=%h ov=%b ovr=%b, want crc=%h ov=1 ovr=1", a_crc, a_ov, a_ovr, x2);
    end
    a_send(mk(32'h35, 6), 1'b1, x2);
    a_idle;
    tests++;
    if (a_cd !== 1'b1 || a_ok !== 1'b1 || a_ovr !== 1'b0 || a_ov !== 1'b1 || a_crc !== x3) begin
      fails++; $display("FAIL ovr_simul: got cd=%b ok=%b ovr=%b ov=%b crc=%h, want cd=1 ok=1 ovr=0 ov=1 crc=%h", a_cd, a_ok, a_ovr, a_ov, a_crc, x3);
    end
    a_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, x3, 1'b0);
    a_idle;
    tests++;
    if (a_cd !== 1'b1 || a_ok !== 1'b1) begin
      fails++; $display("FAIL ovr_held: got cd=%b ok=%b, want cd=1 ok=1", a_cd, a_ok);
    end
  endtask

  task automatic test_saturate;
    for (int k = 0; k < 5; k++) begin
      b_drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
      b_idle;
      tests++;
      if (b_cd !== 1'b1 || b_ok !== 1'b0) begin
        fails++; $display("FAIL sat_chk %0d: got cd=%b ok=%b, want cd=1 ok=0", k, b_cd, b_ok);
      end
      b_drive(1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      b_idle;
    end
    tests++;
    if (b_cnt !== (EN ? 2'd3 : 2'd0)) begin
      fails++; $display("FAIL sat_cnt: got %0d, want %0d", b_cnt, EN ? 3 : 0);
    end
    b_drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
    b_drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    tests++;
    if (b_cd !== 1'b1 || b_ok !== 1'b0) begin
      fails++; $display("FAIL clr_chk: got cd=%b ok=%b, want cd=1 ok=0", b_cd, b_ok);
    end
    b_idle;
    tests++;
    if (b_cnt !== 2'd0) begin
      fails++; $display("FAIL clr_prio: got %0d, want 0", b_cnt);
    end
  endtask

  task automatic test_reset_mid;
    a_drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    a_drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    a_idle;
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({a_crc, a_ov, a_cd, a_ok, a_ovr, a_cnt} !== '0) begin
      fails++; $display("FAIL rst_mid: got crc=%h ov=%b cd=%b ok=%b ovr=%b cnt=%0d, want all 0", a_crc, a_ov, a_cd, a_ok, a_ovr, a_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    a_send(mk(32'h8, 4), 1'b0, 4'h0);
    a_idle;
    tests++;
    if (a_ov !== 1'b1 || a_crc !== 4'hB) begin
      fails++; $display("FAIL rst_block: got crc=%h ov=%b, want crc=b ov=1", a_crc, a_ov);
    end
  endtask

  task automatic test_random;
    bq_t msg;
    logic [3:0] exp, held, r, nib;
    bit pend;
    int cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pend = 1'b0;
    cnt = 0;
    held = '0;
    for (int b = 0; b < 30; b++) begin
      int gar = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      int len = $urandom_range(1, 20);
      for (int g = 0; g < gar; g++) a_drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      msg.delete();
      for (int i = 0; i < len; i++) begin
        logic d = 1'($urandom_range(0, 1));
        logic f = (i == 0) || ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0)
          a_drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 4'h0, 1'b0);
        if (f) msg.delete();
        msg.push_back(d);
        a_drive(1'b1, d, f, i == len - 1, 1'b0, 4'h0, 1'b0);
      end
      exp = crc_ref(msg);
      a_idle;
      tests++;
      if (a_ov !== 1'b1 || a_crc !== exp || a_ovr !== pend) begin
        fails++; $display("FAIL rnd_a blk %0d: got crc=%h ov=%b ovr=%b, want crc=%h ov=1 ovr=%b", b, a_crc, a_ov, a_ovr, exp, pend);
      end
      pend = 1'b1;
      held = exp;
      if ($urandom_range(0, 2) != 0) begin
        r = ($urandom_range(0, 1) == 1) ? held : held ^ 4'($urandom_range(1, 15));
        a_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, r, 1'b0);
        a_idle;
        tests++;
        if (a_cd !== 1'b1 || a_ok !== (r == held)) begin
          fails++; $display("FAIL rnd_chk blk %0d: got cd=%b ok=%b, want cd=1 ok=%b", b, a_cd, a_ok, r == held);
        end
        if (r != held && cnt < 255) cnt++;
        pend = 1'b0;
        a_idle;
        tests++;
        if (a_cnt !== 8'(EN ? cnt : 0)) begin
          fails++; $display("FAIL rnd_cnt blk %0d: got %0d, want %0d", b, a_cnt, EN ? cnt : 0);
        end
      end
    end
    for (int b = 0; b < 15; b++) begin
      int beats = $urandom_range(1, 5);
      msg.delete();
      for (int i = 0; i < beats; i++) begin
        nib = 4'($urandom);
        for (int k = 3; k >= 0; k--) msg.push_back(nib[k]);
        b_drive(1'b1, nib, i == 0, i == beats - 1, 1'b0, 4'h0, 1'b0);
      end
      exp = crc_ref(msg);
      b_idle;
      tests++;
      if (b_ov !== 1'b1 || b_crc !== exp) begin
        fails++; $display("FAIL rnd_b blk %0d: got crc=%h ov=%b, want crc=%h ov=1", b, b_crc, b_ov, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_serial;
    test_parallel;
    test_check;
    test_ovr;
    test_saturate;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
